// File: rtl/myproject_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : myproject_mul_pkg
// Brief    : Shared widths, operand/result types and saturation bounds for
//            the shared-multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package myproject_mul_pkg;

    localparam int DIN0_W = 12;
    localparam int DIN1_W = 10;
    localparam int DOUT_W = 20;
    localparam int PROD_W = DIN0_W + DIN1_W;

    typedef logic signed [DIN0_W-1:0] din0_t;
    typedef logic signed [DIN1_W-1:0] din1_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [DOUT_W-1:0] dout_t;

    localparam prod_t SAT_MAX = prod_t'((1 << (DOUT_W - 1)) - 1);
    localparam prod_t SAT_MIN = prod_t'(-(1 << (DOUT_W - 1)));

endpackage
`default_nettype wire

// File: rtl/myproject_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : myproject_rr_arb
// Brief    : NUM_REQ-wide round-robin arbiter with one-hot grant and index;
//            the pointer moves past the winner after every grant.
// Revision : 1.0 - initial release
// ============================================================================
module myproject_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    import myproject_mul_pkg::*;

    localparam logic [ID_W:0] C_NUM = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   ptr_inc;
    logic            found;

    // Scan NUM_REQ slots starting at the pointer; first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (cand >= C_NUM) begin
                cand = cand - C_NUM;
            end
            if (!found && en && req[cand[ID_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[ID_W-1:0]]    = 1'b1;
                grant_idx                = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (ID_W + 1)'(1);
        if (ptr_inc == C_NUM) begin
            ptr_inc = '0;
        end
        ptr_d = found ? ptr_inc[ID_W-1:0] : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/myproject_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : myproject_mul_share_sched
// Brief    : Time-shares one signed DIN0_W x DIN1_W multiplier among NUM_REQ
//            requesters through a round-robin arbiter and a one-deep
//            valid/ready output slot. Define MUL_SAT_EN to clamp results.
// Revision : 1.0 - initial release
// ============================================================================
module myproject_mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int DIN0_W  = myproject_mul_pkg::DIN0_W,
    parameter int DIN1_W  = myproject_mul_pkg::DIN1_W,
    parameter int DOUT_W  = myproject_mul_pkg::DOUT_W,
    parameter int ID_W    = 2
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
    input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DOUT_W-1:0]         out_dout,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_sat
);
    import myproject_mul_pkg::*;

    localparam int                        C_PROD_W  = DIN0_W + DIN1_W;
    localparam logic signed [C_PROD_W-1:0] C_SAT_MAX = C_PROD_W'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [C_PROD_W-1:0] C_SAT_MIN = C_PROD_W'(-(1 << (DOUT_W - 1)));

    logic                        slot_free;
    logic                        arb_en;
    logic [NUM_REQ-1:0]          grant;
    logic [ID_W-1:0]             grant_idx;
    logic                        xfer;
    logic signed [DIN0_W-1:0]    sel_din0;
    logic signed [DIN1_W-1:0]    sel_din1;
    logic signed [C_PROD_W-1:0]  prod;
    logic [DOUT_W-1:0]           res;
    logic                        res_sat;

    logic                        out_valid_q, out_valid_d;
    logic [DOUT_W-1:0]           out_dout_q,  out_dout_d;
    logic [ID_W-1:0]             out_id_q,    out_id_d;
    logic                        out_sat_q,   out_sat_d;

    // Gating with the reset keeps req_ready low while reset is held.
    assign slot_free = !out_valid_q || out_ready;
    assign arb_en    = slot_free && ap_rst_n;
    assign xfer      = |grant;
    assign req_ready = grant;

    myproject_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .req       (req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_din0 = req_din0[grant_idx*DIN0_W +: DIN0_W];
    assign sel_din1 = req_din1[grant_idx*DIN1_W +: DIN1_W];
    assign prod     = sel_din0 * sel_din1;

`ifdef MUL_SAT_EN
    always_comb begin
        res     = prod[DOUT_W-1:0];
        res_sat = 1'b0;
        if (prod > C_SAT_MAX) begin
            res     = C_SAT_MAX[DOUT_W-1:0];
            res_sat = 1'b1;
        end else if (prod < C_SAT_MIN) begin
            res     = C_SAT_MIN[DOUT_W-1:0];
            res_sat = 1'b1;
        end
    end
`else
    logic unused_prod_hi;
    assign unused_prod_hi = ^{prod[C_PROD_W-1:DOUT_W], C_SAT_MAX, C_SAT_MIN};
    assign res            = prod[DOUT_W-1:0];
    assign res_sat        = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_dout_d  = out_dout_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        if (slot_free) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_dout_d = res;
            out_id_d   = grant_idx;
            out_sat_d  = res_sat;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_dout_q  <= '0;
            out_id_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_dout_q  <= out_dout_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dout  = out_dout_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mul_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_myproject_mul_share_sched
// Brief    : Self-checking bench: behavioural scheduler model compared every
//            cycle, plus hand-computed directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_mul_share_sched;

    localparam int NUM_REQ = 4;
    localparam int DIN0_W  = 12;
    localparam int DIN1_W  = 10;
    localparam int DOUT_W  = 20;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DIN0_W-1:0] req_din0;
    logic [NUM_REQ*DIN1_W-1:0] req_din1;
    logic                      out_valid;
    logic                      out_ready;
    logic [DOUT_W-1:0]         out_dout;
    logic [ID_W-1:0]           out_id;
    logic                      out_sat;

    int n_cmp = 0;
    int n_bad = 0;

    myproject_mul_share_sched #(
        .NUM_REQ (NUM_REQ),
        .DIN0_W  (DIN0_W),
        .DIN1_W  (DIN1_W),
        .DOUT_W  (DOUT_W),
        .ID_W    (ID_W)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dout  (out_dout),
        .out_id    (out_id),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic   m_valid;
    longint m_dout;
    int     m_id;
    logic   m_sat;
    int     m_ptr;

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_dout  <= 0;
            m_id    <= 0;
            m_sat   <= 1'b0;
            m_ptr   <= 0;
        end else begin
            int     g;
            longint a, b, p, w;
            g = exp_grant();
            if (g >= 0) begin
                a = longint'($signed(req_din0[g*DIN0_W +: DIN0_W]));
                b = longint'($signed(req_din1[g*DIN1_W +: DIN1_W]));
                p = a * b;
`ifdef MUL_SAT_EN
                if (p > 524287)       begin w = 524287;  m_sat <= 1'b1; end
                else if (p < -524288) begin w = -524288; m_sat <= 1'b1; end
                else                  begin w = p;       m_sat <= 1'b0; end
`else
                w = ((p % 1048576) + 1048576) % 1048576;
                if (w >= 524288) w = w - 1048576;
                m_sat <= 1'b0;
`endif
                m_dout  <= w;
                m_id    <= g;
                m_valid <= 1'b1;
                m_ptr   <= (g + 1) % NUM_REQ;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] er;
        er = '0;
        g  = exp_grant();
        if (g >= 0) er[g] = 1'b1;
        check("model req_ready", longint'(req_ready), longint'(er));
        check("model out_valid", longint'(out_valid), longint'(m_valid));
        if (m_valid) begin
            check("model out_dout", longint'($signed(out_dout)), m_dout);
            check("model out_id",   longint'(out_id),   longint'(m_id));
            check("model out_sat",  longint'(out_sat),  longint'(m_sat));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_op(input int i, input int a, input int b);
        req_din0[i*DIN0_W +: DIN0_W] = DIN0_W'(a);
        req_din1[i*DIN1_W +: DIN1_W] = DIN1_W'(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] pat_valid [8] = '{8'h5, 8'hA, 8'hF, 8'h0, 8'h9, 8'hC, 8'h3, 8'hF};
    logic       pat_ready [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_dout",  longint'(out_dout),  0);
        check("reset req_ready", longint'(req_ready), 0);
        step();
        rst_n = 1'b1;

        // 1: single request
        step();
        req_valid = 4'b0001;
        set_op(0, 100, -3);
        out_ready = 1'b1;
        @(negedge clk);
        check("t1 req_ready", longint'(req_ready), 1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1 out_valid", longint'(out_valid), 1);
        check("t1 out_dout",  longint'($signed(out_dout)), -300);
        check("t1 out_id",    longint'(out_id), 0);

        // 2: all requesting, rotating grants
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 37 * i - 90, 11 - 7 * i);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2 grant order", longint'(req_ready), longint'(1 << (i % 4)));
            step();
            set_op(i % 4, 300 - 113 * i, 25 * i - 200);
        end

        // 3: stall, slot holds id 3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3 stall req_ready", longint'(req_ready), 0);
            check("t3 stall out_id",    longint'(out_id), 3);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3 resume grant", longint'(req_ready), 1);
        step();

        // 4/5: extreme products (pointer now at 1)
        req_valid = 4'b0010;
        set_op(1, -2048, -512);
        @(negedge clk);
        check("t4 req_ready", longint'(req_ready), 2);
        step();
        req_valid = 4'b0100;
        set_op(2, 2047, 511);
        @(negedge clk);
`ifdef MUL_SAT_EN
        check("t4 out_dout", longint'($signed(out_dout)), 524287);
        check("t4 out_sat",  longint'(out_sat), 1);
`else
        check("t4 out_dout", longint'($signed(out_dout)), 0);
        check("t4 out_sat",  longint'(out_sat), 0);
`endif
        check("t5 req_ready", longint'(req_ready), 4);
        step();
        req_valid = '0;
        @(negedge clk);
`ifdef MUL_SAT_EN
        check("t5 out_dout", longint'($signed(out_dout)), 524287);
        check("t5 out_sat",  longint'(out_sat), 1);
`else
        check("t5 out_dout", longint'($signed(out_dout)), -2559);
        check("t5 out_sat",  longint'(out_sat), 0);
`endif

        // 6: asynchronous reset while the slot is full
        step();
        req_valid = 4'b1000;
        set_op(3, -77, 45);
        out_ready = 1'b0;
        step();
        req_valid = '0;
        @(negedge clk);
        check("t6 pre out_valid", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async out_valid", longint'(out_valid), 0);
        check("t6 async out_dout",  longint'(out_dout), 0);
        check("t6 async out_id",    longint'(out_id), 0);
        check("t6 async req_ready", longint'(req_ready), 0);
        req_valid = 4'b1111;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6 tie winner", longint'(req_ready), 1);
        step();

        // mixed valid/backpressure patterns, checked by the model
        for (int i = 0; i < 8; i++) begin
            req_valid = pat_valid[i][NUM_REQ-1:0];
            out_ready = pat_ready[i];
            for (int j = 0; j < NUM_REQ; j++) set_op(j, 500 - 211 * i + 97 * j, 13 * j - 41 * i);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
